// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared types and constants for the 8-digit 7-segment scan driver.
//   scan_state_t : FSM encoding (ST_BLANK, ST_SHOW)
//   SCAN_ORDER   : slot -> digit index table, element 0 is slot 0
//   SEG_*        : active-low glyphs in {g,f,e,d,c,b,a} order
package seg7_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Slots 0..7 visit digits 3,2,1,0 then 7,6,5,4 (each group MSD first).
  localparam logic [7:0][2:0] SCAN_ORDER = {3'd4, 3'd5, 3'd6, 3'd7,
                                            3'd0, 3'd1, 3'd2, 3'd3};

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [7:0] AN_OFF   = 8'hFF;

  function automatic logic [2:0] slot_to_index(input logic [2:0] slot);
    return SCAN_ORDER[slot];
  endfunction

  // Active-low one-cold anode pattern for a digit index.
  function automatic logic [7:0] anode_for(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to 7-segment decoder, active-low outputs.
//   bcd  in  4  BCD nibble; 10-15 decode to a dash as an error marker
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode display.
//   clk              in   1  system clock
//   reset            in   1  synchronous, active-high
//   enable           in   1  1 = scan, 0 = dark with scan position frozen
//   extracted_digit  in   4  BCD nibble from digit_extractor for digit_index
//   dp_mask          in   8  per-digit decimal point, 1 = lit
//   digit_index      out  3  registered digit select to digit_extractor
//   seg              out  7  {g,f,e,d,c,b,a}, active-low
//   dp               out  1  decimal point, active-low
//   an               out  8  anode enables, active-low
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zeros per
// 4-digit group; each group always keeps its LSD, and a lit decimal point
// forces the digit on).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BLANK | all anodes off; digit_index is settling in the extractor
// ST_SHOW  | one anode low, seg/dp hold the value captured on entry
module seg7_scan_driver
  import seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] extracted_digit,
  input  logic [7:0] dp_mask,
  output logic [2:0] digit_index,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int PS_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [PS_W-1:0] PS_BLANK = PS_W'(BLANK_CYCLES - 1);

  scan_state_t     state;
  logic [2:0]      slot;
  logic [PS_W-1:0] prescaler;
  logic [6:0]      decoded_seg;
  logic            suppress;
  logic [2:0]      next_slot;

  bcd_to_seg7 u_decode (
    .bcd (extracted_digit),
    .seg (decoded_seg)
  );

  assign next_slot = slot + 3'd1;

`ifdef LEADING_ZERO_BLANK_EN
  logic nz_seen;

  // Indices 0 and 4 are group LSDs and are never suppressed.
  assign suppress = (extracted_digit == 4'd0) && !nz_seen &&
                    (digit_index != 3'd0) && (digit_index != 3'd4) &&
                    !dp_mask[digit_index];

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_seen <= 1'b0;
    end else if (enable) begin
      if (state == ST_BLANK && prescaler == PS_BLANK) begin
        if (!suppress && extracted_digit != 4'd0)
          nz_seen <= 1'b1;
      end else if (state == ST_SHOW && prescaler == PS_LAST) begin
        if (next_slot == 3'd0 || next_slot == 3'd4)
          nz_seen <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BLANK;
      slot        <= 3'd0;
      digit_index <= slot_to_index(3'd0);
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      prescaler   <= '0;
    end else if (!enable) begin
      // Freeze position; a full BLANK period follows re-enable.
      state     <= ST_BLANK;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      prescaler <= '0;
    end else begin
      prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      case (state)
        ST_BLANK: begin
          an  <= AN_OFF;
          seg <= SEG_OFF;
          dp  <= 1'b1;
          if (prescaler == PS_BLANK) begin
            state <= ST_SHOW;
            if (!suppress) begin
              an  <= anode_for(digit_index);
              seg <= decoded_seg;
              dp  <= ~dp_mask[digit_index];
            end
          end
        end
        ST_SHOW: begin
          if (prescaler == PS_LAST) begin
            state       <= ST_BLANK;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            slot        <= next_slot;
            digit_index <= slot_to_index(next_slot);
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

endmodule
